apf_video_out: RTL and testbench

Output formatter between the NES palette/emphasis video stage and the Analogue Pocket scaler video bus. It samples the 24-bit RGB pixel, sync and blank signals on each pixel-enable cycle. It converts level syncs into one-pixel-wide HS/VS strobes and gates RGB with a data-enable. On every active line it emits the scaler end-of-line command word, and it reports frame/line/pixel measurements for debug.

---
 rtl/apf_video_out_if.sv | 25 ++
 rtl/apf_video_out.sv | 160 ++++++++++++++++
 tb/tb_apf_video_out.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/apf_video_out_if.sv
// Video bus between the NES palette stage and the Pocket scaler output formatter.
// The master modport is the pixel source; the slave modport is the formatter.
interface apf_video_out_if;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hsync;
    logic        vsync;
    logic        hblank;
    logic        vblank;
    logic [23:0] video_rgb;
    logic        video_de;
    logic        video_hs;
    logic        video_vs;

    modport master (
        output r, g, b, hsync, vsync, hblank, vblank,
        input  video_rgb, video_de, video_hs, video_vs
    );

    modport slave (
        input  r, g, b, hsync, vsync, hblank, vblank,
        output video_rgb, video_de, video_hs, video_vs
    );
endinterface

// File: rtl/apf_video_out.sv
// Formats NES video for the Analogue Pocket scaler: sync strobes, DE-gated RGB,
// end-of-line command word, and frame/line/pixel measurements for debug.
module apf_video_out #(
    parameter int CNT_W    = 16,
    parameter int HS_DELAY = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic [2:0]       scaler_slot,
    apf_video_out_if.slave   vid,
    output logic [CNT_W-1:0] frame_count,
    output logic [8:0]       lines_per_frame,
    output logic [8:0]       pixels_per_line,
    output logic             locked
);

    typedef enum logic {
        WAIT_VS,
        RUN
    } state_t;

    localparam logic [1:0] HOLD_INIT = 2'(HS_DELAY);
    localparam logic [8:0] CNT_MAX   = 9'd511;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_prev_hsync;
    logic             r_prev_vsync;
    logic             r_hs_pend;
    logic [1:0]       r_hold;
    logic [23:0]      r_rgb;
    logic             r_de;
    logic             r_hs;
    logic             r_vs;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [8:0]       r_line_cnt;
    logic [8:0]       r_pix_cnt;
    logic [8:0]       r_lpf;
    logic [8:0]       r_ppl;
    logic             r_locked;

    logic             w_hs_rise;
    logic             w_vs_rise;
    logic             w_de_in;
    logic             w_active;
    logic             w_hs_block;
    logic             w_hs_req;
    logic             w_hs;
    logic             w_hs_pend_next;
    logic             w_de;
    logic             w_eol;
    logic [23:0]      w_rgb;
    logic [1:0]       w_hold_next;
    logic [8:0]       w_line_inc;

    assign w_hs_rise  = vid.hsync & ~r_prev_hsync;
    assign w_vs_rise  = vid.vsync & ~r_prev_vsync;
    assign w_de_in    = ~vid.hblank & ~vid.vblank;
    assign w_line_inc = (r_line_cnt == CNT_MAX) ? CNT_MAX : r_line_cnt + 9'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_VS;
        end else if (ce_pix) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == WAIT_VS && w_vs_rise) begin
            w_state_next = RUN;
        end
    end

    // The VS pixel itself is allowed to queue an HS even while still waiting,
    // so an hsync rising together with the very first vsync is not lost.
    always_comb begin
        w_active       = (r_state == RUN);
        w_hs_block     = w_vs_rise | (r_hold != 2'd0);
        w_hs_req       = (w_active | w_vs_rise) & (w_hs_rise | r_hs_pend);
        w_hs           = w_hs_req & ~w_hs_block;
        w_hs_pend_next = w_hs_req & w_hs_block;
        w_de           = w_active & w_de_in;
        w_eol          = w_active & r_de & ~w_de_in;
        w_rgb          = 24'd0;
        if (w_de) begin
            w_rgb = {vid.r, vid.g, vid.b};
        end else if (w_eol) begin
            w_rgb = {13'd0, scaler_slot, 8'd0};
        end
        w_hold_next = r_hold;
        if (w_vs_rise) begin
            w_hold_next = HOLD_INIT;
        end else if (r_hold != 2'd0) begin
            w_hold_next = r_hold - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_hsync <= 1'b0;
            r_prev_vsync <= 1'b0;
            r_hs_pend    <= 1'b0;
            r_hold       <= 2'd0;
            r_rgb        <= 24'd0;
            r_de         <= 1'b0;
            r_hs         <= 1'b0;
            r_vs         <= 1'b0;
        end else if (ce_pix) begin
            r_prev_hsync <= vid.hsync;
            r_prev_vsync <= vid.vsync;
            r_hs_pend    <= w_hs_pend_next;
            r_hold       <= w_hold_next;
            r_rgb        <= w_rgb;
            r_de         <= w_de;
            r_hs         <= w_hs;
            r_vs         <= w_vs_rise;
        end
    end

    // When the line ends on the VS pixel, the latched count includes that line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_line_cnt  <= 9'd0;
            r_pix_cnt   <= 9'd0;
            r_lpf       <= 9'd0;
            r_ppl       <= 9'd0;
            r_locked    <= 1'b0;
        end else if (ce_pix) begin
            if (w_eol) begin
                r_ppl     <= r_pix_cnt;
                r_pix_cnt <= 9'd0;
            end else if (w_de && r_pix_cnt != CNT_MAX) begin
                r_pix_cnt <= r_pix_cnt + 9'd1;
            end
            if (w_vs_rise) begin
                r_lpf       <= w_eol ? w_line_inc : r_line_cnt;
                r_line_cnt  <= 9'd0;
                r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                r_locked    <= 1'b1;
            end else if (w_eol) begin
                r_line_cnt <= w_line_inc;
            end
        end
    end

    assign vid.video_rgb   = r_rgb;
    assign vid.video_de    = r_de;
    assign vid.video_hs    = r_hs;
    assign vid.video_vs    = r_vs;
    assign frame_count     = r_frame_cnt;
    assign lines_per_frame = r_lpf;
    assign pixels_per_line = r_ppl;
    assign locked          = r_locked;

endmodule

// File: tb/tb_apf_video_out.sv
// Scoreboard bench for apf_video_out on a shrunken raster (16x6 active, 24x10 total),
// with a second instance (CNT_W=2, HS_DELAY=0) to exercise counter wrap and HS deferral.
module tb_apf_video_out;

    localparam int ACT_W   = 16;
    localparam int TOT_W   = 24;
    localparam int ACT_H   = 6;
    localparam int TOT_H   = 10;
    localparam int VS_LINE = 7;
    localparam int HS_COL  = 18;

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        locked;
        logic [15:0] fc;
        logic [8:0]  lpf;
        logic [8:0]  ppl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_pix = 1'b0;
    logic [2:0]  scalerSlot = 3'd3;
    logic [15:0] frameCount;
    logic [8:0]  linesPerFrame;
    logic [8:0]  pixelsPerLine;
    logic        locked;
    logic [1:0]  frameCount2;
    logic [8:0]  linesPerFrame2;
    logic [8:0]  pixelsPerLine2;
    logic        locked2;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t queue1[$];
    exp_t queue2[$];

    bit   runExp = 1'b0;
    int   fcExp = 0;
    int   vsSinceReset = 0;
    logic [8:0] lpfExp = 9'd0;
    logic [8:0] pplExp = 9'd0;

    apf_video_out_if vif ();
    apf_video_out_if vif2 ();

    assign vif2.r      = vif.r;
    assign vif2.g      = vif.g;
    assign vif2.b      = vif.b;
    assign vif2.hsync  = vif.hsync;
    assign vif2.vsync  = vif.vsync;
    assign vif2.hblank = vif.hblank;
    assign vif2.vblank = vif.vblank;

    apf_video_out #(.CNT_W(16), .HS_DELAY(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ce_pix          (ce_pix),
        .scaler_slot     (scalerSlot),
        .vid             (vif.slave),
        .frame_count     (frameCount),
        .lines_per_frame (linesPerFrame),
        .pixels_per_line (pixelsPerLine),
        .locked          (locked)
    );

    apf_video_out #(.CNT_W(2), .HS_DELAY(0)) dut2 (
        .clk             (clk),
        .reset_n         (reset_n),
        .ce_pix          (ce_pix),
        .scaler_slot     (scalerSlot),
        .vid             (vif2.slave),
        .frame_count     (frameCount2),
        .lines_per_frame (linesPerFrame2),
        .pixels_per_line (pixelsPerLine2),
        .locked          (locked2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s t=%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    function automatic logic [63:0] actual1();
        return {vif.video_rgb, vif.video_de, vif.video_hs, vif.video_vs, locked,
                frameCount, linesPerFrame, pixelsPerLine};
    endfunction

    function automatic logic [63:0] actual2();
        return {vif2.video_rgb, vif2.video_de, vif2.video_hs, vif2.video_vs, locked2,
                14'd0, frameCount2, linesPerFrame2, pixelsPerLine2};
    endfunction

    // Expected output of each pixel follows directly from its raster position:
    // DE on cols 0..15 of lines 0..5, EOL word at col 16, HS where hsync rises.
    task automatic applyStimulus(input int line, input int col, input int vsCol);
        exp_t  e1;
        exp_t  e2;
        logic  hb;
        logic  vb;
        logic  vsRise;
        logic  de;
        logic  eol;
        logic  [23:0] pix;
        int    hsPix1;
        int    hsPix2;
        hb     = (col >= ACT_W);
        vb     = (line >= ACT_H);
        pix    = (hb || vb) ? 24'h123456 : {8'(line), 8'(col), 8'hA5};
        vsRise = (line == VS_LINE && col == vsCol);
        de     = runExp && !hb && !vb;
        eol    = runExp && !vb && (col == ACT_W);
        hsPix1 = (vsCol == HS_COL && line == VS_LINE) ? HS_COL + 3 : HS_COL;
        hsPix2 = (vsCol == HS_COL && line == VS_LINE) ? HS_COL + 1 : HS_COL;
        if (vsRise) begin
            fcExp++;
            lpfExp = (vsSinceReset == 0) ? 9'd0 : 9'(ACT_H);
            vsSinceReset++;
        end
        if (eol) pplExp = 9'(ACT_W);
        e1.rgb    = de ? pix : (eol ? (24'(scalerSlot) << 8) : 24'h000000);
        e1.de     = de;
        e1.hs     = (runExp || vsRise) && (col == hsPix1);
        e1.vs     = vsRise;
        e1.locked = runExp || vsRise;
        e1.fc     = 16'(fcExp);
        e1.lpf    = lpfExp;
        e1.ppl    = pplExp;
        e2        = e1;
        e2.hs     = (runExp || vsRise) && (col == hsPix2);
        e2.fc     = {14'd0, 2'(fcExp)};
        runExp    = runExp || vsRise;

        @(negedge clk);
        vif.r      = pix[23:16];
        vif.g      = pix[15:8];
        vif.b      = pix[7:0];
        vif.hsync  = (col >= HS_COL && col < HS_COL + 4);
        vif.vsync  = (line == VS_LINE && col >= vsCol) || (line == VS_LINE + 1 && col < vsCol);
        vif.hblank = hb;
        vif.vblank = vb;
        ce_pix     = 1'b1;
        queue1.push_back(e1);
        queue2.push_back(e2);
        @(negedge clk);
        ce_pix = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic midFrameReset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_dut1", actual1(), 64'd0);
        checkOutput("midreset_dut2", actual2(), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n      = 1'b1;
        runExp       = 1'b0;
        fcExp        = 0;
        vsSinceReset = 0;
        lpfExp       = 9'd0;
        pplExp       = 9'd0;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            if (ce_pix) begin
                #1;
                if (queue1.size() == 0 || queue2.size() == 0) begin
                    checkOutput("unexpected_pixel", 64'd1, 64'd0);
                end else begin
                    checkOutput("pixel_dut1", actual1(), queue1.pop_front());
                    checkOutput("pixel_dut2", actual2(), queue2.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        reset_n    = 1'b1;
        vif.r      = 8'd0;
        vif.g      = 8'd0;
        vif.b      = 8'd0;
        vif.hsync  = 1'b0;
        vif.vsync  = 1'b0;
        vif.hblank = 1'b1;
        vif.vblank = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_dut1", actual1(), 64'd0);
        checkOutput("reset_dut2", actual2(), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int frame = 0; frame < 7; frame++) begin
            int vsCol;
            vsCol = (frame == 2) ? HS_COL : 0;
            if (frame == 2) scalerSlot = 3'd5;
            if (frame == 4) scalerSlot = 3'd3;
            for (int line = 0; line < TOT_H; line++) begin
                for (int col = 0; col < TOT_W; col++) begin
                    applyStimulus(line, col, vsCol);
                    if (frame == 3 && line == 3 && col == 10) midFrameReset();
                end
            end
        end

        repeat (8) @(negedge clk);
        checkOutput("queue_drain", 64'(queue1.size() + queue2.size()), 64'd0);
        checkOutput("final_frame_count", {48'd0, frameCount}, 64'd4);
        checkOutput("final_frame_count_wrap", {62'd0, frameCount2}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
